pkt_router_mc: RTL and testbench
================================

PKT_ROUTER_MC -- requirements
Module: pkt_router_mc

Interface
REQ-001 Parameter PKT_BITS, default 72, packet width in bits.
REQ-002 Parameter KEY_BITS, default 32, routing key width.
REQ-003 Parameter KEY_LSB, default 8, LSB position of the key within the packet.
REQ-004 Parameter NUM_CHANS, default 8, output channel count (2..16).
REQ-005 Parameter NUM_RREGS, default 16, routing table entries (1..64).
REQ-006 clk  in  1  sole clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 drop_wait_in  in  32  cycles a blocked packet waits before it is dropped.
REQ-009 reg_key_in  in  NUM_RREGS*KEY_BITS  flattened entry keys, entry i at [i*KEY_BITS +: KEY_BITS].
REQ-010 reg_mask_in  in  NUM_RREGS*KEY_BITS  flattened entry masks.
REQ-011 reg_route_in  in  NUM_RREGS*NUM_CHANS  flattened one-hot or multicast channel masks per entry.
REQ-012 pkt_in_data_in / pkt_in_vld_in / pkt_in_rdy_out  in/in/out  PKT_BITS/1/1  input packet handshake.
REQ-013 pkt_out_data_out / pkt_out_vld_out / pkt_out_rdy_in  out/out/in  NUM_CHANS*PKT_BITS/NUM_CHANS/NUM_CHANS  per-channel output handshakes.
REQ-014 rt_cnt_out  out  2  one-cycle pulses: [0] packet dropped, [1] packet routed.

Function
REQ-015 Entry i hits when (key & mask[i]) == key[i]; the lowest-index hit wins; route is that entry's NUM_CHANS-bit mask; a miss, or a hit whose mask is all zero, yields route 0.
REQ-016 Stage L register captures packet and route on the input handshake; lookup uses the table values present in the capture cycle; later table changes do not affect a captured packet.
REQ-017 pkt_in_rdy_out = !L_vld || L_done, where L_done is dispatch or drop this cycle; one packet per cycle at full rate.
REQ-018 Dispatch occurs when L_vld, route != 0, and every selected channel c has !out_vld[c] || pkt_out_rdy_in[c]; the packet is then written to all selected channel registers in the same cycle (atomic multicast).
REQ-019 Route 0 drops the packet in its first L cycle, without any wait.
REQ-020 Blocked = L_vld && route != 0 && dispatch condition false.
REQ-021 Wait counter loads drop_wait_in on every non-blocked cycle, decrements on blocked cycles, and forces a drop on a blocked cycle with count 0; the drop therefore occurs on blocked cycle drop_wait_in+1.
REQ-022 Output registers: vld sets on dispatch and clears on the rdy handshake; dispatch takes priority over clear in the same cycle; data is stable while vld && !rdy.
REQ-023 Latency: a packet accepted at edge t has its out_vld asserted after edge t+1, i.e. visible in cycle t+1, two edges after acceptance counting from presentation.
REQ-024 rt_cnt_out[1] pulses once per dispatched packet (not once per channel); rt_cnt_out[0] pulses once per miss or timeout drop; the two pulses are never high together.
REQ-025 No packet is duplicated on a channel, reordered within a channel, or lost except by a REQ-019/REQ-021 drop.

Reset
REQ-026 While reset is high at a clk edge: L_vld=0, all out_vld=0, wait counter=0, data registers=0, rt_cnt_out=0, and pkt_in_rdy_out=1 from the next cycle.
REQ-027 Reset mid-operation discards L and output contents with no drop pulse.

Structure
REQ-028 Package pkt_router_pkg holds default parameter constants, the max-entry limit, and the rt_cnt bit indices (CNT_DROP=0, CNT_ROUTED=1).
REQ-029 Sub-module pkt_router_lookup (CAM compare plus priority encoder, combinational, parametrised) is instantiated once; all state remains in pkt_router_mc.

Verification
REQ-030 Entry0 key=0x10 mask=0xFF route=0x05, all rdy=1, input key 0x10 -> packet appears on channels 0 and 2 one cycle after acceptance; rt_cnt_out[1] pulses once.
REQ-031 Entries 3 and 7 both hit, with routes 0x08 and 0x80 -> only channel 3 receives the packet.
REQ-032 Key matching no entry -> rt_cnt_out[0] pulses in the cycle after acceptance; no out_vld asserted; next packet accepted back-to-back.
REQ-033 drop_wait_in=4, route=0x03, ch1 rdy=0 with out_vld[1] already set -> packet held for 5 blocked cycles, then dropped; no partial write to channel 0.
REQ-034 Same as REQ-033, but ch1 rdy rises on blocked cycle 3 -> dispatch to both channels, no drop pulse, and the counter reloads to 4.
REQ-035 Streaming at 1 packet/cycle with random rdy and reset asserted mid-stream -> scoreboard shows per-channel order preserved, the REQ-026 reset state holds, and the first post-reset packet routes correctly.

Source files
------------

// File: rtl/pkt_router_pkg.sv
// Shared constants for the multicast packet router: parameter defaults,
// table size limit and rt_cnt_out bit positions.
package pkt_router_pkg;

  localparam int unsigned DEF_PKT_BITS  = 72;
  localparam int unsigned DEF_KEY_BITS  = 32;
  localparam int unsigned DEF_KEY_LSB   = 8;
  localparam int unsigned DEF_NUM_CHANS = 8;
  localparam int unsigned DEF_NUM_RREGS = 16;

  localparam int unsigned MAX_RREGS = 64;

  localparam int unsigned CNT_DROP   = 0;
  localparam int unsigned CNT_ROUTED = 1;

endpackage

// File: rtl/pkt_router_lookup.sv
// Routing table match: masked compare against every entry, lowest-index hit
// supplies the channel mask; a miss yields an all-zero route.
module pkt_router_lookup
  import pkt_router_pkg::*;
#(
  parameter int unsigned KEY_BITS  = DEF_KEY_BITS,
  parameter int unsigned NUM_CHANS = DEF_NUM_CHANS,
  parameter int unsigned NUM_RREGS = DEF_NUM_RREGS
) (
  input  logic [KEY_BITS-1:0]            key,
  input  logic [NUM_RREGS*KEY_BITS-1:0]  reg_key,
  input  logic [NUM_RREGS*KEY_BITS-1:0]  reg_mask,
  input  logic [NUM_RREGS*NUM_CHANS-1:0] reg_route,
  output logic [NUM_CHANS-1:0]           route
);

  logic found;

  always_comb begin
    route = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_RREGS; i++) begin
      if (!found && ((key & reg_mask[i*KEY_BITS +: KEY_BITS]) == reg_key[i*KEY_BITS +: KEY_BITS])) begin
        route = reg_route[i*NUM_CHANS +: NUM_CHANS];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_router_mc.sv
// Single-stage multicast router: table lookup at capture, atomic dispatch to
// all selected channel registers, timed drop of packets blocked too long.
module pkt_router_mc
  import pkt_router_pkg::*;
#(
  parameter int unsigned PKT_BITS  = DEF_PKT_BITS,
  parameter int unsigned KEY_BITS  = DEF_KEY_BITS,
  parameter int unsigned KEY_LSB   = DEF_KEY_LSB,
  parameter int unsigned NUM_CHANS = DEF_NUM_CHANS,
  parameter int unsigned NUM_RREGS = DEF_NUM_RREGS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [31:0]                    drop_wait_in,
  input  logic [NUM_RREGS*KEY_BITS-1:0]  reg_key_in,
  input  logic [NUM_RREGS*KEY_BITS-1:0]  reg_mask_in,
  input  logic [NUM_RREGS*NUM_CHANS-1:0] reg_route_in,
  input  logic [PKT_BITS-1:0]            pkt_in_data_in,
  input  logic                           pkt_in_vld_in,
  output logic                           pkt_in_rdy_out,
  output logic [NUM_CHANS*PKT_BITS-1:0]  pkt_out_data_out,
  output logic [NUM_CHANS-1:0]           pkt_out_vld_out,
  input  logic [NUM_CHANS-1:0]           pkt_out_rdy_in,
  output logic [1:0]                     rt_cnt_out
);

  logic                          l_vld;
  logic [PKT_BITS-1:0]           l_data;
  logic [NUM_CHANS-1:0]          l_route;
  logic [31:0]                   wait_cnt;
  logic [NUM_CHANS-1:0]          out_vld;
  logic [NUM_CHANS*PKT_BITS-1:0] out_data;

  logic [NUM_CHANS-1:0] route_lu;
  logic [NUM_CHANS-1:0] ch_free;
  logic                 dispatch;
  logic                 blocked;
  logic                 drop;
  logic                 accept;

  pkt_router_lookup #(
    .KEY_BITS (KEY_BITS),
    .NUM_CHANS(NUM_CHANS),
    .NUM_RREGS(NUM_RREGS)
  ) u_lookup (
    .key      (pkt_in_data_in[KEY_LSB +: KEY_BITS]),
    .reg_key  (reg_key_in),
    .reg_mask (reg_mask_in),
    .reg_route(reg_route_in),
    .route    (route_lu)
  );

  always_comb begin
    ch_free  = ~out_vld | pkt_out_rdy_in;
    dispatch = l_vld && (l_route != '0) && ((l_route & ~ch_free) == '0);
    blocked  = l_vld && (l_route != '0) && !dispatch;
    drop     = l_vld && ((l_route == '0) || (blocked && (wait_cnt == '0)));
  end

  assign pkt_in_rdy_out   = !l_vld || dispatch || drop;
  assign accept           = pkt_in_vld_in && pkt_in_rdy_out;
  assign pkt_out_vld_out  = out_vld;
  assign pkt_out_data_out = out_data;

  // Pulses are decoded from L directly; masking with reset keeps a packet
  // discarded by reset from reporting a drop or dispatch.
  assign rt_cnt_out[CNT_DROP]   = drop && !reset;
  assign rt_cnt_out[CNT_ROUTED] = dispatch && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      l_vld    <= 1'b0;
      l_data   <= '0;
      l_route  <= '0;
      wait_cnt <= '0;
      out_vld  <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        l_vld   <= 1'b1;
        l_data  <= pkt_in_data_in;
        l_route <= route_lu;
      end else if (dispatch || drop) begin
        l_vld <= 1'b0;
      end

      wait_cnt <= (blocked && (wait_cnt != '0)) ? wait_cnt - 32'd1 : drop_wait_in;

      for (int unsigned c = 0; c < NUM_CHANS; c++) begin
        if (dispatch && l_route[c]) begin
          out_vld[c]                         <= 1'b1;
          out_data[c*PKT_BITS +: PKT_BITS] <= l_data;
        end else if (pkt_out_rdy_in[c]) begin
          out_vld[c] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pkt_router_mc.sv
// Bench for pkt_router_mc: directed routing/drop/timeout cases, then a random
// stream with a mid-stream reset checked against a per-channel queue model.
module tb_pkt_router_mc;
  import pkt_router_pkg::*;

  localparam int unsigned PB = 72;
  localparam int unsigned KB = 32;
  localparam int unsigned KL = 8;
  localparam int unsigned NC = 8;
  localparam int unsigned NR = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [31:0]     drop_wait;
  logic [NR*KB-1:0] reg_key, reg_mask;
  logic [NR*NC-1:0] reg_route;
  logic [PB-1:0]   in_data;
  logic            in_vld, in_rdy;
  logic [NC*PB-1:0] out_data;
  logic [NC-1:0]   out_vld, out_rdy;
  logic [1:0]      rt_cnt;

  logic [KB-1:0] tbl_key [NR];
  logic [KB-1:0] tbl_mask[NR];
  logic [NC-1:0] tbl_route[NR];

  int checks = 0;
  int failures = 0;

  logic [PB-1:0] exp_q [NC][$];
  int exp_routed, exp_drop, got_routed, got_drop;
  logic sb_on = 1'b0;
  logic [NC-1:0] sb_route;
  logic [PB-1:0] sb_pkt;

  always #5 clk = ~clk;

  always_comb begin
    reg_key = '0; reg_mask = '0; reg_route = '0;
    for (int i = 0; i < NR; i++) begin
      reg_key[i*KB +: KB]   = tbl_key[i];
      reg_mask[i*KB +: KB]  = tbl_mask[i];
      reg_route[i*NC +: NC] = tbl_route[i];
    end
  end

  pkt_router_mc #(
    .PKT_BITS(PB), .KEY_BITS(KB), .KEY_LSB(KL), .NUM_CHANS(NC), .NUM_RREGS(NR)
  ) dut (
    .clk(clk), .reset(reset), .drop_wait_in(drop_wait),
    .reg_key_in(reg_key), .reg_mask_in(reg_mask), .reg_route_in(reg_route),
    .pkt_in_data_in(in_data), .pkt_in_vld_in(in_vld), .pkt_in_rdy_out(in_rdy),
    .pkt_out_data_out(out_data), .pkt_out_vld_out(out_vld), .pkt_out_rdy_in(out_rdy),
    .rt_cnt_out(rt_cnt)
  );

  task automatic check(input string tag, input logic [PB*NC-1:0] obs, input logic [PB*NC-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC-1:0] model_route(input logic [KB-1:0] key);
    for (int i = 0; i < NR; i++)
      if ((key & tbl_mask[i]) == tbl_key[i]) return tbl_route[i];
    return '0;
  endfunction

  function automatic logic [PB-1:0] mk_pkt(input logic [KB-1:0] key);
    logic [31:0] hi;
    logic [7:0]  lo;
    hi = $urandom;
    lo = 8'($urandom);
    return {hi, key, lo};
  endfunction

  function automatic logic [PB-1:0] chan(input int c);
    return out_data[c*PB +: PB];
  endfunction

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < NR; i++) begin
      tbl_key[i] = 32'hDEAD_BEEF; tbl_mask[i] = '1; tbl_route[i] = '0;
    end
  endtask

  task automatic rand_entry(input int i);
    tbl_mask[i]  = $urandom;
    tbl_key[i]   = $urandom & tbl_mask[i];
    tbl_route[i] = ($urandom_range(0, 7) == 0) ? '0 : NC'($urandom);
  endtask

  // Scoreboard: packets are queued per selected channel at acceptance using
  // the table visible in that cycle, and popped on each output handshake.
  always @(negedge clk) begin
    if (sb_on) begin
      if (reset) begin
        for (int c = 0; c < NC; c++) exp_q[c].delete();
        exp_routed = 0; exp_drop = 0; got_routed = 0; got_drop = 0;
      end else begin
        if (rt_cnt[CNT_ROUTED]) got_routed++;
        if (rt_cnt[CNT_DROP]) got_drop++;
        if (rt_cnt == 2'b11) check("sb_pulse_excl", rt_cnt, 2'b00);
        for (int c = 0; c < NC; c++) begin
          if (out_vld[c] && out_rdy[c]) begin
            check("sb_expected_pkt", exp_q[c].size() != 0, 1);
            if (exp_q[c].size() != 0) begin
              sb_pkt = exp_q[c].pop_front();
              check("sb_data", chan(c), sb_pkt);
            end
          end
        end
        if (in_vld && in_rdy) begin
          sb_route = model_route(in_data[KL +: KB]);
          if (sb_route == '0) exp_drop++;
          else begin
            exp_routed++;
            for (int c = 0; c < NC; c++) if (sb_route[c]) exp_q[c].push_back(in_data);
          end
        end
      end
    end
  end

  initial begin
    logic [PB-1:0] p, q, p0, p1, p2;
    logic [KB-1:0] k;
    int j;

    reset = 1'b1; in_vld = 1'b0; in_data = '0; out_rdy = '1; drop_wait = 32'd4;
    clear_tbl();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mid();
    check("rst_out_vld", out_vld, '0);
    check("rst_rt_cnt", rt_cnt, '0);
    check("rst_in_rdy", in_rdy, 1);
    check("rst_out_data", out_data, '0);
    check("rst_wait_cnt", dut.wait_cnt, 0);

    // Multicast to channels 0 and 2
    tbl_key[0] = 32'h10; tbl_mask[0] = 32'hFF; tbl_route[0] = 8'h05;
    next(); p = mk_pkt(32'h10); in_data = p; in_vld = 1'b1;
    mid(); check("mc_in_rdy", in_rdy, 1);
    next(); in_vld = 1'b0;
    mid(); check("mc_routed_pulse", rt_cnt, 2'b10); check("mc_vld_early", out_vld, '0);
    next();
    mid(); check("mc_vld", out_vld, 8'h05); check("mc_ch0", chan(0), p);
    check("mc_ch2", chan(2), p); check("mc_pulse_once", rt_cnt, '0);
    next();
    mid(); check("mc_cleared", out_vld, '0);

    // Two hits: lowest index wins
    tbl_key[3] = 32'h20; tbl_mask[3] = 32'hFF; tbl_route[3] = 8'h08;
    tbl_key[7] = 32'h20; tbl_mask[7] = 32'hFF; tbl_route[7] = 8'h80;
    next(); p = mk_pkt(32'h20); in_data = p; in_vld = 1'b1;
    next(); in_vld = 1'b0;
    next();
    mid(); check("prio_vld", out_vld, 8'h08); check("prio_ch3", chan(3), p);

    // Miss then back-to-back hit
    next(); p = mk_pkt(32'h99); in_data = p; in_vld = 1'b1;
    next(); q = mk_pkt(32'h10); in_data = q;
    mid(); check("miss_rdy", in_rdy, 1); check("miss_drop_pulse", rt_cnt, 2'b01);
    check("miss_no_vld", out_vld, '0);
    next(); in_vld = 1'b0;
    mid(); check("b2b_routed_pulse", rt_cnt, 2'b10); check("b2b_no_vld", out_vld, '0);
    next();
    mid(); check("b2b_vld", out_vld, 8'h05); check("b2b_ch0", chan(0), q);

    // Timeout: ch1 held busy, packet for ch0|ch1 dropped on blocked cycle 5
    tbl_key[1] = 32'h30; tbl_mask[1] = 32'hFF; tbl_route[1] = 8'h03;
    tbl_key[2] = 32'h40; tbl_mask[2] = 32'hFF; tbl_route[2] = 8'h02;
    next(); p0 = mk_pkt(32'h40); in_data = p0; in_vld = 1'b1; out_rdy = 8'hFD;
    next(); in_vld = 1'b0;
    next();
    mid(); check("to_pre_vld", out_vld, 8'h02);
    next(); p1 = mk_pkt(32'h30); in_data = p1; in_vld = 1'b1;
    mid(); check("to_accept_rdy", in_rdy, 1);
    next(); in_vld = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      if (b > 1) next();
      mid();
      check("to_wait_cnt", dut.wait_cnt, 5 - b);
      check("to_rt_cnt", rt_cnt, (b == 5) ? 2'b01 : 2'b00);
      check("to_in_rdy", in_rdy, (b == 5) ? 1 : 0);
    end
    next();
    mid(); check("to_no_partial", out_vld, 8'h02); check("to_ch0_kept", chan(0), q);
    check("to_ch1_kept", chan(1), p0); check("to_reload", dut.wait_cnt, 4);

    // Blocked then released on blocked cycle 3
    next(); p2 = mk_pkt(32'h30); in_data = p2; in_vld = 1'b1;
    next(); in_vld = 1'b0;
    mid(); check("rel_b1_cnt", dut.wait_cnt, 4); check("rel_b1_rt", rt_cnt, '0);
    next();
    mid(); check("rel_b2_cnt", dut.wait_cnt, 3);
    next(); out_rdy = '1;
    mid(); check("rel_b3_routed", rt_cnt, 2'b10); check("rel_b3_cnt", dut.wait_cnt, 2);
    next();
    mid(); check("rel_vld", out_vld, 8'h03); check("rel_ch0", chan(0), p2);
    check("rel_ch1", chan(1), p2); check("rel_reload", dut.wait_cnt, 4);
    check("rel_no_drop", rt_cnt, '0);

    // Random stream with mid-stream reset
    drop_wait = 32'd1000;
    for (int i = 0; i < NR; i++) rand_entry(i);
    next();
    exp_routed = 0; exp_drop = 0; got_routed = 0; got_drop = 0;
    sb_on = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (n > 0) next();
      if (n == 200) reset = 1'b1;
      if (n == 202) reset = 1'b0;
      if (n % 16 == 0) rand_entry($urandom_range(0, NR - 1));
      if ($urandom_range(0, 3) != 0) begin
        j = $urandom_range(0, NR - 1);
        k = (tbl_key[j] & tbl_mask[j]) | ($urandom & ~tbl_mask[j]);
      end else k = $urandom;
      in_data = mk_pkt(k);
      in_vld  = ($urandom_range(0, 3) != 0);
      out_rdy = NC'($urandom) | NC'($urandom);
      if (n == 202) begin
        mid();
        check("rs_out_vld", out_vld, '0); check("rs_rt_cnt", rt_cnt, '0);
        check("rs_in_rdy", in_rdy, 1); check("rs_out_data", out_data, '0);
        check("rs_wait_cnt", dut.wait_cnt, 0);
      end
    end
    next(); in_vld = 1'b0; out_rdy = '1;
    repeat (12) next();
    mid();
    sb_on = 1'b0;
    for (int c = 0; c < NC; c++) check("drain_queue_empty", exp_q[c].size(), 0);
    check("drain_routed_count", got_routed, exp_routed);
    check("drain_drop_count", got_drop, exp_drop);
    check("drain_idle", out_vld, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
